// File: rtl/display_sched_pkg.sv
// Shared types for the display source scheduler.
// The GAP state only exists when DISPLAY_SCHED_GAP_EN is defined.
package display_sched_pkg;

    // Number of requesters sharing the display when not overridden.
    localparam int unsigned NUM_SRC_DEFAULT = 4;

    // One word as shown on the seven-segment display.
    typedef logic [31:0] disp_word_t;

`ifdef DISPLAY_SCHED_GAP_EN
    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        GAP
    } sched_state_t;
`else
    typedef enum logic {
        IDLE,
        SHOW
    } sched_state_t;
`endif

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: selects the first requesting index
// after last_idx, wrapping modulo NUM_SRC. Output pick is one-hot.
module rr_arbiter
    import display_sched_pkg::*;
#(
    parameter int unsigned NUM_SRC = NUM_SRC_DEFAULT,
    parameter int unsigned IDX_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   last_idx,
    output logic [NUM_SRC-1:0] pick,
    output logic               valid
);

    logic [IDX_W-1:0] pos;
    logic             found;

    // Scan from last_idx+1 upward (wrapping); the first hit wins.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        pos   = '0;
        for (int unsigned off = 1; off <= NUM_SRC; off++) begin
            pos = IDX_W'((32'(last_idx) + off) % NUM_SRC);
            if (!found && req[pos]) begin
                pick[pos] = 1'b1;
                found     = 1'b1;
            end
        end
        valid = found;
    end

endmodule

// File: rtl/display_source_scheduler.sv
// Time-shares one seven-segment display between NUM_SRC requesters.
// Each grant lasts DWELL_CYCLES unless the owner drops its request.
// Optional feature macro: DISPLAY_SCHED_GAP_EN inserts GAP_CYCLES blank
// cycles after every grant.
module display_source_scheduler
    import display_sched_pkg::*;
#(
    parameter int unsigned NUM_SRC      = NUM_SRC_DEFAULT,
    parameter int unsigned DWELL_CYCLES = 50000000,
    parameter int unsigned GAP_CYCLES   = 5000000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic       [NUM_SRC-1:0] req,
    input  disp_word_t [NUM_SRC-1:0] value_in,
    output logic       [NUM_SRC-1:0] grant,
    output logic       [NUM_SRC-1:0] done,
    output disp_word_t               value_out,
    output logic                     blank
);

    localparam int unsigned IDX_W = $clog2(NUM_SRC);
    localparam int unsigned CNT_W = $clog2(DWELL_CYCLES);
    localparam logic [IDX_W-1:0] LAST_RST   = IDX_W'(NUM_SRC - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

    if (NUM_SRC < 2 || NUM_SRC > 8) begin : g_bad_num_src
        $error("display_source_scheduler: NUM_SRC must be 2..8");
    end
    if (DWELL_CYCLES < 2) begin : g_bad_dwell
        $error("display_source_scheduler: DWELL_CYCLES must be >= 2");
    end
    if (GAP_CYCLES < 1) begin : g_bad_gap
        $error("display_source_scheduler: GAP_CYCLES must be >= 1");
    end

    sched_state_t       state;
    sched_state_t       state_next;
    logic [IDX_W-1:0]   last_idx;   // owner index while in SHOW
    logic [IDX_W-1:0]   pick_idx;
    logic [CNT_W-1:0]   dwell_cnt;
    logic [NUM_SRC-1:0] pick;
    logic               pick_valid;
    logic [NUM_SRC-1:0] owner_oh;
    logic               owner_req;
    logic               dwell_end;

    rr_arbiter #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req      (req),
        .last_idx (last_idx),
        .pick     (pick),
        .valid    (pick_valid)
    );

    // Convert the arbiter's one-hot pick into an index.
    always_comb begin
        pick_idx = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (pick[i]) begin
                pick_idx = IDX_W'(i);
            end
        end
    end

    assign owner_oh  = NUM_SRC'(1) << last_idx;
    assign owner_req = req[last_idx];
    assign dwell_end = (dwell_cnt == DWELL_LAST);

`ifdef DISPLAY_SCHED_GAP_EN
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    logic [GAP_W-1:0] gap_cnt;
    logic             gap_end;

    assign gap_end = (gap_cnt == GAP_LAST);

    // Gap counter runs only while blanking and rests at zero otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt <= '0;
        end else if (state == GAP) begin
            gap_cnt <= gap_end ? '0 : gap_cnt + 1'b1;
        end else begin
            gap_cnt <= '0;
        end
    end

    assign blank = (state == GAP);
`else
    assign blank = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic plus grant/done decode from the registered owner.
    always_comb begin
        state_next = state;
        grant      = '0;
        done       = '0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_next = SHOW;
                end
            end
            SHOW: begin
                grant = owner_oh;
                // A dropped request releases silently; done only on a full dwell.
                if (owner_req && dwell_end) begin
                    done = owner_oh;
                end
                if (!owner_req || dwell_end) begin
`ifdef DISPLAY_SCHED_GAP_EN
                    state_next = GAP;
`else
                    state_next = IDLE;
`endif
                end
            end
`ifdef DISPLAY_SCHED_GAP_EN
            GAP: begin
                if (gap_end) begin
                    state_next = IDLE;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    // Owner capture, dwell counting and the registered display value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_idx  <= LAST_RST;
            dwell_cnt <= '0;
            value_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        last_idx  <= pick_idx;
                        dwell_cnt <= '0;
                        value_out <= value_in[pick_idx];
                    end
                end
                SHOW: begin
                    value_out <= value_in[last_idx];
                    dwell_cnt <= (state_next == SHOW) ? dwell_cnt + 1'b1 : '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_display_source_scheduler.sv
// Self-checking bench for display_source_scheduler (NUM_SRC=4,
// DWELL_CYCLES=4, GAP_CYCLES=2). Honours DISPLAY_SCHED_GAP_EN if defined.
module tb_display_source_scheduler;

    localparam int NS = 4;
    localparam int DW = 4;
`ifdef DISPLAY_SCHED_GAP_EN
    localparam int GAPLEN = 2;
`else
    localparam int GAPLEN = 0;
`endif
    localparam int P = 1 + DW + GAPLEN;

    logic              clk;
    logic              rst_n;
    logic [NS-1:0]     req;
    logic [NS-1:0][31:0] value_in;
    logic [NS-1:0]     grant;
    logic [NS-1:0]     done;
    logic [31:0]       value_out;
    logic              blank;

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the display and for how long.
    int          m_owner;
    int          m_cnt;
    int          m_gap;
    int          m_last;
    logic [31:0] m_vout;

    logic [NS-1:0] prev_grant;
    logic [NS-1:0] grant_log[$];
    logic [NS-1:0] done_log[$];

    display_source_scheduler #(
        .NUM_SRC      (NS),
        .DWELL_CYCLES (DW),
        .GAP_CYCLES   (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .value_in  (value_in),
        .grant     (grant),
        .done      (done),
        .value_out (value_out),
        .blank     (blank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_owner = -1;
        m_cnt   = 0;
        m_gap   = 0;
        m_last  = NS - 1;
        m_vout  = '0;
    endfunction

    // One clock of the scheduling rules, applied to the inputs seen at the edge.
    function automatic void model_step();
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (m_owner >= 0) begin
            m_vout = value_in[m_owner];
            if (!req[m_owner] || m_cnt == DW - 1) begin
                m_owner = -1;
                m_gap   = GAPLEN;
            end else begin
                m_cnt++;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else if (req != '0) begin
            for (int k = 1; k <= NS; k++) begin
                int i;
                i = (m_last + k) % NS;
                if (req[i]) begin
                    m_owner = i;
                    break;
                end
            end
            m_last = m_owner;
            m_cnt  = 0;
            m_vout = value_in[m_owner];
        end
    endfunction

    // Compare current outputs with the model, then advance one clock.
    task automatic cycle();
        logic [NS-1:0] eg;
        logic [NS-1:0] ed;
        #1;
        eg = (m_owner >= 0) ? NS'(1 << m_owner) : '0;
        ed = (m_owner >= 0 && req[m_owner] && m_cnt == DW - 1) ? eg : '0;
        chk("model_grant", 32'(grant), 32'(eg));
        chk("model_done", 32'(done), 32'(ed));
        chk("model_blank", 32'(blank), 32'(m_gap > 0));
        chk("model_value_out", value_out, m_vout);
        if (grant != '0 && prev_grant == '0) grant_log.push_back(grant);
        if (done != '0) done_log.push_back(done);
        prev_grant = grant;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic wait_grant(input string tag, input logic [NS-1:0] want, input int budget);
        int n;
        n = 0;
        while (grant !== want && n < budget) begin
            cycle();
            n++;
        end
        chk(tag, 32'(grant), 32'(want));
    endtask

    initial begin
        rst_n      = 1'b0;
        req        = '0;
        value_in   = '0;
        prev_grant = '0;
        model_reset();

        // Reset state
        repeat (3) cycle();
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_value_out", value_out, 32'h0);
        chk("rst_blank", 32'(blank), 32'h0);
        rst_n = 1'b1;

        // Sole requester: grant latency, dwell, done, one idle cycle, re-grant
        value_in[0] = 32'h1234;
        value_in[1] = 32'h1111;
        value_in[2] = 32'h2222;
        value_in[3] = 32'h3333;
        req = 4'b0001;
        cycle();
        chk("sole_grant", 32'(grant), 32'h1);
        chk("sole_value", value_out, 32'h1234);
        chk("sole_no_done", 32'(done), 32'h0);
        cycle();
        cycle();
        cycle();
        chk("sole_done", 32'(done), 32'h1);
        for (int g = 0; g < GAPLEN; g++) begin
            cycle();
            chk("gap_blank", 32'(blank), 32'h1);
            chk("gap_grant", 32'(grant), 32'h0);
        end
        cycle();
        chk("sole_idle_grant", 32'(grant), 32'h0);
        chk("sole_idle_blank", 32'(blank), 32'h0);
        cycle();
        chk("sole_regrant", 32'(grant), 32'h1);

        // All requesting: rotation order and one done per grant
        do_reset();
        req = 4'b1111;
        grant_log.delete();
        done_log.delete();
        repeat (4 * P + 2) cycle();
        chk("rr_count", 32'(grant_log.size()), 32'd5);
        chk("rr_done_count", 32'(done_log.size()), 32'd4);
        if (grant_log.size() == 5 && done_log.size() == 4) begin
            chk("rr_g0", 32'(grant_log[0]), 32'h1);
            chk("rr_g1", 32'(grant_log[1]), 32'h2);
            chk("rr_g2", 32'(grant_log[2]), 32'h4);
            chk("rr_g3", 32'(grant_log[3]), 32'h8);
            chk("rr_g4", 32'(grant_log[4]), 32'h1);
            chk("rr_d0", 32'(done_log[0]), 32'h1);
            chk("rr_d3", 32'(done_log[3]), 32'h8);
        end

        // Owner 2 releases on its 2nd SHOW cycle
        do_reset();
        value_in[3] = 32'hA;
        req = 4'b1111;
        wait_grant("rel_owner2", 4'b0100, 40);
        cycle();
        done_log.delete();
        req = 4'b1011;
        #1;
        chk("rel_no_done_now", 32'(done), 32'h0);
        cycle();
        chk("rel_grant_clear", 32'(grant), 32'h0);
        wait_grant("rel_next_owner3", 4'b1000, 20);
        chk("rel_no_done", 32'(done_log.size()), 32'd0);

        // Live value tracking for owner 3
        chk("live_value_a", value_out, 32'hA);
        value_in[3] = 32'hB;
        cycle();
        chk("live_value_b", value_out, 32'hB);

        // Reset asserted on the 3rd SHOW cycle
        do_reset();
        req = 4'b0001;
        value_in[0] = 32'h1234;
        cycle();
        cycle();
        cycle();
        chk("abort_pre_grant", 32'(grant), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("abort_grant", 32'(grant), 32'h0);
        chk("abort_done", 32'(done), 32'h0);
        chk("abort_value", value_out, 32'h0);
        chk("abort_blank", 32'(blank), 32'h0);
        cycle();
        rst_n = 1'b1;
        req = 4'b1111;
        cycle();
        chk("abort_first_src0", 32'(grant), 32'h1);

        // Randomised traffic against the model
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0) value_in[2'($urandom_range(0, 3))] = $urandom;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/display_source_scheduler.md
DISPLAY_SOURCE_SCHEDULER -- requirements
Module: display_source_scheduler

Interface
REQ-001 Parameter NUM_SRC, default 4: number of requesters sharing the seven-segment display, legal range 2..8.
REQ-002 Parameter DWELL_CYCLES, default 50000000: clk cycles one source owns the display per grant, minimum 2.
REQ-003 Parameter GAP_CYCLES, default 5000000: blank cycles between grants when the gap feature is compiled in, minimum 1.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 req  input  NUM_SRC  per-source display request, level-sensitive.
REQ-007 value_in  input  NUM_SRC x 32  per-source value to show.
REQ-008 grant  output  NUM_SRC  one-hot owner of the display; all-zero when unowned.
REQ-009 done  output  NUM_SRC  one-cycle pulse to the owner when its dwell completes.
REQ-010 value_out  output  32  registered value driven to the display controller's value input.
REQ-011 blank  output  1  high while the display must show nothing.

Function
REQ-012 States SHALL be IDLE, SHOW and GAP, where GAP exists only with the gap feature.
REQ-013 In IDLE with any req bit set, the scheduler SHALL pick the first requesting index after last_idx, wrapping modulo NUM_SRC, and enter SHOW on the next edge.
REQ-014 grant SHALL assert one cycle after the req sample that won, together with the first SHOW cycle.
REQ-015 While in SHOW, value_out SHALL register value_in of the owner every cycle, giving one-cycle latency, so a live owner value is tracked.
REQ-016 The dwell counter SHALL load 0 on SHOW entry and increment each SHOW cycle.
REQ-017 At count DWELL_CYCLES-1, done[owner] SHALL pulse for exactly that cycle, and grant SHALL clear on the next edge.
REQ-018 If req[owner] drops during SHOW, the owner SHALL be released on the next edge without a done pulse.
REQ-019 last_idx SHALL update to the owner on each SHOW entry.
REQ-020 value_out SHALL hold its last value outside SHOW.
REQ-021 There SHALL be at least one IDLE cycle between consecutive grants, including re-grant of the same sole requester.
REQ-022 grant SHALL never have more than one bit set, and done SHALL only pulse on the bit currently granted.

Reset
REQ-023 While rst_n is low: state IDLE, grant 0, done 0, value_out 0, blank 0, counters 0, last_idx NUM_SRC-1, so source 0 wins first.
REQ-024 Reset asserted mid-SHOW or mid-GAP SHALL abort immediately with no done pulse.

Configuration
REQ-025 Macro DISPLAY_SCHED_GAP_EN defined: SHOW exit, whether by done or by release, SHALL enter GAP for GAP_CYCLES cycles with blank=1, then return to IDLE.
REQ-026 Macro DISPLAY_SCHED_GAP_EN undefined: GAP SHALL be absent, blank SHALL be tied 0, and SHOW exit SHALL go directly to IDLE.

Structure
REQ-027 Package display_sched_pkg SHALL hold the state enum type, the 32-bit display word typedef and the NUM_SRC default constant.
REQ-028 Sub-module rr_arbiter SHALL be a combinational round-robin picker with inputs req and last_idx and outputs a one-hot pick plus a valid flag.

Verification (NUM_SRC=4, DWELL_CYCLES=4, GAP_CYCLES=2)
REQ-029 Reset then req=4'b0001 held, value_in[0]=32'h1234: grant=0001 and value_out=32'h1234 one cycle after req, done[0] pulse on the 4th SHOW cycle, re-grant after one IDLE cycle.
REQ-030 req=4'b1111 held: grants SHALL follow 0001, 0010, 0100, 1000, 0001, with one done pulse each.
REQ-031 Owner 2 drops req on its 2nd SHOW cycle: grant clears next edge, no done pulse, and next grant goes to index 3 if requesting.
REQ-032 value_in[owner] changes from 32'hA to 32'hB mid-SHOW: value_out shows 32'hB one cycle later.
REQ-033 With DISPLAY_SCHED_GAP_EN defined: blank=1 for exactly 2 cycles after each SHOW exit and grant=0 throughout. Without it, blank stays 0.
REQ-034 rst_n pulled low on the 3rd SHOW cycle: grant, done and value_out read 0 immediately, and source 0 wins first after release.
